// File: rtl/pixel_sensor_controller_pkg.sv
// Constants and state encoding shared by the pixel array,
// the frame controller and the readout path.
package pixel_sensor_config;

  localparam int PIXEL_BITS   = 8;
  localparam int NUM_ROWS     = 2;
  localparam int ERASE_CYCLES = 5;
  localparam int EXPOSE_BITS  = 8;

  localparam int ROW_W =
    (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  // Wide enough for both erase and exposure lengths
  localparam int ERASE_W = $clog2(ERASE_CYCLES + 1);
  localparam int DCNT_W =
    (EXPOSE_BITS > ERASE_W) ? EXPOSE_BITS : ERASE_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_READ,
    S_DONE
  } pixel_ctrl_state_t;

  function automatic logic [EXPOSE_BITS-1:0] expose_len(
    input logic [EXPOSE_BITS-1:0] t
  );
    return (t == '0) ? EXPOSE_BITS'(1) : t;
  endfunction

endpackage

// File: rtl/pixel_sensor_controller_if.sv
// Camera-control and pixel-array signals of the
// frame controller, bundled as one port.
interface pixel_sensor_controller_if;
  import pixel_sensor_config::*;

  logic                   start;
  logic                   abort;
  logic [EXPOSE_BITS-1:0] expose_time;
  logic                   erase;
  logic                   expose;
  logic                   ramp;
  logic [PIXEL_BITS-1:0]  count_value;
  logic [NUM_ROWS-1:0]    row_select;
  logic                   row_valid;
  logic                   row_ready;
  logic                   busy;
  logic                   frame_done;

  modport master (
    output start, abort, expose_time, row_ready,
    input  erase, expose, ramp, count_value,
    input  row_select, row_valid, busy, frame_done
  );

  modport slave (
    input  start, abort, expose_time, row_ready,
    output erase, expose, ramp, count_value,
    output row_select, row_valid, busy, frame_done
  );

endinterface

// File: rtl/pixel_sensor_controller_counter.sv
// Generic up-counter with synchronous clear and enable.
// Saturation is left to the caller via max_o.
module pixel_sensor_controller_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] q_o,
  output logic             max_o
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i)
      q_d = '0;
    else if (en_i)
      q_d = q_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      q_q <= '0;
    else
      q_q <= q_d;
  end

  assign q_o   = q_q;
  assign max_o = &q_q;

endmodule

// File: rtl/pixel_sensor_controller.sv
// Frame sequencer: erase, expose, ramp conversion and
// row-by-row readout handshake for the pixel array.
module pixel_sensor_controller
  import pixel_sensor_config::*;
(
  input logic clk,
  input logic reset,
  pixel_sensor_controller_if.slave bus
);

  localparam int CW = PIXEL_BITS + 1;

  pixel_ctrl_state_t state_q, state_d;

  logic [DCNT_W-1:0]      dcnt_q, dcnt_d;
  logic [EXPOSE_BITS-1:0] elen_q, elen_d;
  logic [ROW_W-1:0]       row_q, row_d;

  // Bit 0 is the ramp phase, upper bits the count
  logic [CW-1:0] cv;
  logic          cv_max;
  logic          cv_clr;
  logic          cv_en;

  pixel_sensor_controller_counter #(
    .WIDTH (CW)
  ) u_conv_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (cv_clr),
    .en_i  (cv_en),
    .q_o   (cv),
    .max_o (cv_max)
  );

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    elen_d  = elen_q;
    row_d   = row_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ERASE;
          dcnt_d  = DCNT_W'(ERASE_CYCLES - 1);
          elen_d  = expose_len(bus.expose_time);
        end
      end
      S_ERASE: begin
        if (dcnt_q == '0) begin
          state_d = S_EXPOSE;
          dcnt_d  = DCNT_W'(elen_q) - DCNT_W'(1);
        end else begin
          dcnt_d = dcnt_q - DCNT_W'(1);
        end
      end
      S_EXPOSE: begin
        if (dcnt_q == '0)
          state_d = S_CONVERT;
        else
          dcnt_d = dcnt_q - DCNT_W'(1);
      end
      S_CONVERT: begin
        if (cv_max)
          state_d = S_READ;
      end
      S_READ: begin
        if (bus.row_ready) begin
          if (row_q == ROW_W'(NUM_ROWS - 1)) begin
            state_d = S_DONE;
            row_d   = '0;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.abort) begin
      state_d = S_IDLE;
      dcnt_d  = '0;
      row_d   = '0;
    end
  end

  // Count holds at all ones through READ
  assign cv_en  = (state_q == S_CONVERT) && !cv_max;
  assign cv_clr = (state_d != S_CONVERT) &&
                  (state_d != S_READ);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      dcnt_q  <= '0;
      elen_q  <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      elen_q  <= elen_d;
      row_q   <= row_d;
    end
  end

  assign bus.erase       = (state_q == S_ERASE);
  assign bus.expose      = (state_q == S_EXPOSE);
  assign bus.ramp        = (state_q == S_CONVERT) && !cv[0];
  assign bus.count_value = cv[CW-1:1];
  assign bus.row_valid   = (state_q == S_READ);
  assign bus.row_select  = (state_q == S_READ) ?
                           (NUM_ROWS'(1) << row_q) : '0;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.frame_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_pixel_sensor_controller.sv
// Bench for the frame sequencer: per-cycle comparison
// against a timeline model built from phase lengths.
module tb_pixel_sensor_controller;
  import pixel_sensor_config::*;

  localparam int VW = 7 + PIXEL_BITS + NUM_ROWS;
  localparam int STEPS = 1 << PIXEL_BITS;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  pixel_sensor_controller_if bus();

  pixel_sensor_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] obs();
    return {bus.erase, bus.expose, bus.ramp,
            bus.count_value, bus.row_select,
            bus.row_valid, bus.busy, bus.frame_done};
  endfunction

  function automatic logic [VW-1:0] mk(
    input bit er, ex, rp,
    input int cnt, row,
    input bit rv, bz, fd
  );
    logic [PIXEL_BITS-1:0] c;
    logic [NUM_ROWS-1:0]   rs;
    c  = PIXEL_BITS'(cnt);
    rs = '0;
    if (rv) rs[row] = 1'b1;
    return {er, ex, rp, c, rs, rv, bz, fd};
  endfunction

  // One frame from the idle cycle before start to frame_done.
  task automatic run_frame(
    input  int et,
    input  bit hold,
    input  int stall0,
    input  bit rnd,
    output int len
  );
    int e, e2, ce, k, r, stalls;
    bit rd_over, fin, rdy;
    logic [VW-1:0] got, exp_v;
    e  = (et == 0) ? 1 : et;
    e2 = ERASE_CYCLES + e;
    ce = e2 + 2 * STEPS;
    @(negedge clk);
    got = obs();
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL idle_before_start got %h exp 0", got);
    end
    bus.start       = 1'b1;
    bus.expose_time = EXPOSE_BITS'(et);
    bus.row_ready   = rnd ? 1'($urandom) : 1'b1;
    k = 0; r = 0; stalls = 0;
    rd_over = 0; fin = 0; len = 0;
    while (!fin && k < 20000) begin
      @(negedge clk);
      k++;
      if (k <= ERASE_CYCLES)
        exp_v = mk(1, 0, 0, 0, 0, 0, 1, 0);
      else if (k <= e2)
        exp_v = mk(0, 1, 0, 0, 0, 0, 1, 0);
      else if (k <= ce)
        exp_v = mk(0, 0, ((k - e2 - 1) % 2) == 0,
                   (k - e2 - 1) / 2, 0, 0, 1, 0);
      else if (!rd_over)
        exp_v = mk(0, 0, 0, STEPS - 1, r, 1, 1, 0);
      else begin
        exp_v = mk(0, 0, 0, 0, 0, 0, 1, 1);
        fin = 1;
        len = k;
      end
      got = obs();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL frame_cycle_%0d got %h exp %h",
                 k, got, exp_v);
      end
      bus.start = hold;
      // Changes after acceptance must not affect this frame
      if (k == 2 && !hold)
        bus.expose_time = EXPOSE_BITS'($urandom);
      if (k > ce && !rd_over && !fin) begin
        if (r == 0 && stalls < stall0) rdy = 0;
        else if (rnd) rdy = 1'($urandom);
        else rdy = 1;
        if (!rdy) stalls++;
        else if (r == NUM_ROWS - 1) rd_over = 1;
        else r++;
        bus.row_ready = rdy;
      end else begin
        bus.row_ready = rnd ? 1'($urandom) : 1'b1;
      end
    end
    checks++;
    if (len != ce + NUM_ROWS + 1 + stalls) begin
      errors++;
      $display("FAIL frame_length got %0d exp %0d",
               len, ce + NUM_ROWS + 1 + stalls);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.expose_time = 8'd9;
    bus.row_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs() !== '0) begin
      errors++;
      $display("FAIL reset_state got %h exp 0", obs());
    end
    reset = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic test_basic();
    int len;
    run_frame(10, 0, 0, 0, len);
    checks++;
    if (len != 530) begin
      errors++;
      $display("FAIL basic_len got %0d exp 530", len);
    end
  endtask

  task automatic test_zero_expose();
    int len;
    run_frame(0, 0, 0, 0, len);
    checks++;
    if (len != 521) begin
      errors++;
      $display("FAIL zero_expose_len got %0d exp 521", len);
    end
  endtask

  task automatic test_stall();
    int len;
    run_frame(10, 0, 7, 0, len);
    checks++;
    if (len != 537) begin
      errors++;
      $display("FAIL stall_len got %0d exp 537", len);
    end
  endtask

  task automatic test_reset_mid_convert();
    int len;
    @(negedge clk);
    bus.start = 1'b1;
    bus.expose_time = 8'd10;
    // count 37, ramp-high half: 5 + 10 + 2*37 + 1
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    checks++;
    if (bus.count_value !== 8'd37 || bus.ramp !== 1'b1) begin
      errors++;
      $display("FAIL mid_convert_count got %0d exp 37",
               bus.count_value);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== '0) begin
      errors++;
      $display("FAIL mid_convert_reset got %h exp 0", obs());
    end
    reset = 1'b0;
    run_frame(10, 0, 0, 0, len);
  endtask

  task automatic test_abort();
    int act;
    @(negedge clk);
    bus.start = 1'b1;
    bus.expose_time = 8'd20;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bus.start = (k == 2);
    end
    checks++;
    if (bus.expose !== 1'b1 || bus.erase !== 1'b0) begin
      errors++;
      $display("FAIL abort_pre_expose got %b%b exp 01",
               bus.erase, bus.expose);
    end
    bus.abort = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== '0) begin
      errors++;
      $display("FAIL abort_expose got %h exp 0", obs());
    end
    // Still aborting with start high while idle
    @(negedge clk);
    checks++;
    if (obs() !== '0) begin
      errors++;
      $display("FAIL abort_idle got %h exp 0", obs());
    end
    bus.abort = 1'b0;
    bus.start = 1'b0;
    act = 0;
    repeat (600) begin
      @(negedge clk);
      if (bus.busy || bus.frame_done) act++;
    end
    checks++;
    if (act != 0) begin
      errors++;
      $display("FAIL abort_no_frame got %0d exp 0", act);
    end
  endtask

  task automatic test_back_to_back();
    int l1, l2;
    run_frame(10, 1, 0, 0, l1);
    run_frame(3, 0, 0, 0, l2);
    checks++;
    if (l1 != 530 || l2 != 523) begin
      errors++;
      $display("FAIL b2b_len got %0d/%0d exp 530/523",
               l1, l2);
    end
  endtask

  task automatic test_random();
    int len, et;
    for (int i = 0; i < 4; i++) begin
      et = int'($urandom_range(0, 40));
      run_frame(et, 0, int'($urandom_range(0, 4)), 1, len);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_expose();
    test_stall();
    test_reset_mid_convert();
    test_abort();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_sensor_controller.md
Name: pixel_sensor_controller

Overview:
- Sequences one frame of the pixel array: erase, expose, ramp conversion, then a row-by-row readout handshake.
- Drives the shared ERASE, EXPOSE and RAMP lines of every pixel sensor.
- Broadcasts the conversion count that pixels latch when their CMP fires.
- Sits between the top-level camera control and the pixel array / readout mux.

Parameters:
- PIXEL_BITS, 8, width of conversion count; conversion is 2^PIXEL_BITS ramp steps.
- NUM_ROWS, 2, number of readout row groups.
- ERASE_CYCLES, 5, clk cycles erase is held high (must be ≥1).
- EXPOSE_BITS, 8, width of runtime exposure-length input.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  begin a frame; sampled only in IDLE.
- abort  in  1  synchronous abort to IDLE from any state.
- expose_time  in  EXPOSE_BITS  exposure length in cycles; latched when start is accepted.
- erase  out  1  to all pixel ERASE inputs.
- expose  out  1  to all pixel EXPOSE inputs.
- ramp  out  1  to all pixel RAMP inputs.
- count_value  out  PIXEL_BITS  conversion count bus.
- row_select  out  NUM_ROWS  one-hot read enable for the current row.
- row_valid  out  1  current row data is on the bus.
- row_ready  in  1  downstream accepted the current row.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at end of readout.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high, on port reset. On a reset edge:
  - state goes to IDLE;
  - all outputs are 0, including count_value, row_select and frame_done;
  - internal counters and the latched exposure value are 0.
- States: IDLE, ERASE, EXPOSE, CONVERT, READ, DONE. Transitions happen on the clk edge; outputs are registered.
- IDLE:
  - start=1 → ERASE.
  - expose_time is latched at that edge; a value of 0 is latched as 1.
- ERASE:
  - erase=1 for exactly ERASE_CYCLES cycles, then → EXPOSE.
- EXPOSE:
  - expose=1 for exactly the latched exposure length, then → CONVERT.
  - erase and expose are never high together.
- CONVERT:
  - Lasts 2·2^PIXEL_BITS cycles.
  - A phase bit p starts at 0; ramp = ~p.
  - count_value starts at 0 and increments on the edge that ends each p=1 cycle.
  - Ramp pulse k is therefore high while count_value==k, for k = 0 … 2^PIXEL_BITS−1.
  - After the p=1 cycle with count_value = 2^PIXEL_BITS−1: → READ. count_value holds its final value (all ones) through READ and returns to 0 on entry to DONE. No wrap to 0 occurs inside CONVERT.
- READ:
  - Row index r starts at 0; row_select = one-hot(r); row_valid=1.
  - A transfer is the cycle with row_valid && row_ready.
  - On a transfer with r < NUM_ROWS−1: r increments and the next row is presented on the next cycle, with no bubble.
  - On a transfer with r = NUM_ROWS−1: → DONE.
  - row_ready may be held low indefinitely; row_select and row_valid stay stable until the transfer.
- DONE:
  - frame_done=1 for one cycle, then → IDLE.
  - busy=0 from the IDLE cycle onward.
- start handling:
  - start while busy is ignored; it is not queued.
  - start held high continuously yields back-to-back frames, each separated by exactly one IDLE cycle.
- abort:
  - In any non-IDLE state: → IDLE on the next edge with all outputs 0. frame_done is not pulsed.
  - abort in IDLE: remains IDLE, even if start=1 in the same cycle (abort wins).
- reset and abort together: reset semantics, which give the identical result.
- Frame length, start-accept edge to frame_done cycle inclusive, with zero readout stalls: ERASE_CYCLES + E + 2^(PIXEL_BITS+1) + NUM_ROWS + 1 cycles, where E is the latched exposure length.

Decomposition:
- Shared package pixel_sensor_config gets:
  - the state enum typedef pixel_ctrl_state_t;
  - constants PIXEL_BITS, NUM_ROWS and ERASE_CYCLES, so pixel, controller and readout agree.
- One natural sub-module: the existing generic Counter, instantiated for the phase/count_value counter.
- The erase and expose durations use a single shared down-counter inside the controller.

Test Plan:
- Reset mid-CONVERT, with count_value=37 → next cycle all outputs 0, state IDLE; a following start runs a full frame normally.
- PIXEL_BITS=8, NUM_ROWS=2, ERASE_CYCLES=5, expose_time=10, row_ready tied 1, start pulsed one cycle → erase high 5 cycles, expose high 10, exactly 256 ramp pulses with count_value 0…255, row_select 01 then 10, frame_done at cycle 5+10+512+2+1=530.
- expose_time=0 → expose high exactly 1 cycle.
- row_ready low for 7 cycles on row 0 → row_select=01 and row_valid held stable 7 cycles; frame_done delayed by exactly 7 cycles.
- abort asserted during EXPOSE → IDLE next cycle, expose=0, no frame_done pulse; start during busy produces no second frame.
- start held high across two frames → frames back-to-back with one IDLE cycle between; second frame uses the expose_time sampled at its own start edge (e.g. 3).
